data_mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data-memory port. Accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. Performs the access on a synchronous 16-bit word array and returns a single-cycle response. Sits between the controller/datapath memory signals and the data storage, replacing a zero-latency combinational memory.

---
 rtl/data_mem_if.sv | 39 +++
 rtl/data_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Request/response bundle between the CPU data-memory port and data_mem_responder.
// The master modport is the CPU side; the slave modport is the responder side.
interface data_mem_if #(
   parameter int DATA_W = 16
);
   logic              req_valid;
   logic              req_write;
   logic [15:0]       req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic              busy;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err,
      output busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: one request at a time, WAIT_CYCLES stall, one-cycle response.
// Optional macro DATA_MEM_ERR_EN enables the address range check (resp_err, dropped stores).
module data_mem_responder #(
   parameter  int DATA_W      = 16,
   parameter  int DEPTH       = 256,
   parameter  int WAIT_CYCLES = 2,
   localparam int IDX_W       = $clog2(DEPTH)
) (
   input  logic      clk,
   input  logic      rst_n,
   data_mem_if.slave mem_bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

   state_e              state_q;
   state_e              state_d;
   logic [3:0]          cnt_q;
   logic [3:0]          cnt_d;
   logic                write_q;
   logic [15:0]         addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   rdata_d;
   logic                err_q;
   logic                err_d;
   logic                ready_q;
   logic                ready_d;
   logic                busy_q;
   logic                busy_d;
   logic                valid_q;
   logic                valid_d;
   logic                capture_s;
   logic                access_s;
   logic                in_range_s;
   logic                mem_we_s;
   logic [IDX_W-1:0]    idx_s;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   assign idx_s = addr_q[IDX_W-1:0];

`ifdef DATA_MEM_ERR_EN
   localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);
   assign in_range_s = ({1'b0, addr_q} < DEPTH_EXT);
`else
   logic addr_hi_unused_s;
   // Without the range check the address simply aliases through its low bits.
   assign in_range_s       = 1'b1;
   assign addr_hi_unused_s = ^addr_q;
`endif

   // Next-state, wait counter and registered-output next values.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      capture_s = 1'b0;
      access_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (mem_bus.req_valid) begin
               capture_s = 1'b1;
               cnt_d     = WAIT_LOAD;
               state_d   = S_WAIT;
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               access_s = 1'b1;
               state_d  = S_RESP;
            end else begin
               cnt_d    = cnt_q - 4'd1;
               state_d  = S_WAIT;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      valid_d = (state_d == S_RESP);
   end

   // Access result: stores echo their data, out-of-range loads read as zero.
   always_comb begin
      rdata_d  = rdata_q;
      err_d    = err_q;
      mem_we_s = 1'b0;
      if (access_s) begin
         err_d = ~in_range_s;
         if (write_q) begin
            rdata_d  = wdata_q;
            mem_we_s = in_range_s;
         end else if (in_range_s) begin
            rdata_d  = mem_q[idx_s];
         end else begin
            rdata_d  = {DATA_W{1'b0}};
         end
      end else begin
         mem_we_s = 1'b0;
      end
   end

   // Control state and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   // Request capture; only values latched in IDLE are ever used.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q <= 1'b0;
         addr_q  <= 16'd0;
         wdata_q <= {DATA_W{1'b0}};
      end else if (capture_s) begin
         write_q <= mem_bus.req_write;
         addr_q  <= mem_bus.req_addr;
         wdata_q <= mem_bus.req_wdata;
      end
   end

   // Response data and error hold until the next access edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= {DATA_W{1'b0}};
         err_q   <= 1'b0;
      end else begin
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage array is deliberately not reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_q[idx_s] <= wdata_q;
      end
   end

   assign mem_bus.req_ready  = ready_q;
   assign mem_bus.busy       = busy_q;
   assign mem_bus.resp_valid = valid_q;
   assign mem_bus.resp_rdata = rdata_q;
   assign mem_bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed steps plus randomized traffic
// against an array-based reference model, on a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance.
module tb_data_mem_responder;

`ifdef DATA_MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   bit          sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = 16'd0;
   logic [15:0] req_wdata = 16'd0;

   logic        obs_ready, obs_valid, obs_err, obs_busy;
   logic [15:0] obs_rdata;

   int checks = 0;
   int failures = 0;

   bit [15:0] model   [2][DEPTH];
   bit        written [2][DEPTH];

   data_mem_if #(.DATA_W(16)) ifa ();
   data_mem_if #(.DATA_W(16)) if0 ();

   data_mem_responder #(.DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem_bus (ifa)
   );

   data_mem_responder #(.DATA_W(16), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .mem_bus (if0)
   );

   always #5 clk = ~clk;

   assign ifa.req_valid = req_valid && !sel;
   assign ifa.req_write = req_write;
   assign ifa.req_addr  = req_addr;
   assign ifa.req_wdata = req_wdata;
   assign if0.req_valid = req_valid && sel;
   assign if0.req_write = req_write;
   assign if0.req_addr  = req_addr;
   assign if0.req_wdata = req_wdata;

   assign obs_ready = sel ? if0.req_ready  : ifa.req_ready;
   assign obs_valid = sel ? if0.resp_valid : ifa.resp_valid;
   assign obs_rdata = sel ? if0.resp_rdata : ifa.resp_rdata;
   assign obs_err   = sel ? if0.resp_err   : ifa.resp_err;
   assign obs_busy  = sel ? if0.busy       : ifa.busy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 32'(obs_ready), 32'd1);
      chk({tag, "_valid"}, 32'(obs_valid), 32'd0);
      chk({tag, "_rdata"}, 32'(obs_rdata), 32'd0);
      chk({tag, "_err"},   32'(obs_err),   32'd0);
      chk({tag, "_busy"},  32'(obs_busy),  32'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!obs_ready && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      if (!obs_ready) chk("ready_timeout", 32'(obs_ready), 32'd1);
   endtask

   // One full transaction; expected results come from the array model.
   task automatic xact(input bit w, input logic [15:0] a, input logic [15:0] d, input bit junk);
      int        wt;
      int        lat;
      bit        found;
      bit        exp_e;
      bit        chk_d;
      int        idx;
      logic [15:0] exp_d;
      logic [15:0] held;
      wt    = sel ? 0 : 2;
      idx   = int'(a) % DEPTH;
      exp_e = ERR_EN && (int'(a) >= DEPTH);
      if (w) begin
         exp_d = d;
         chk_d = !exp_e;
         if (!exp_e) begin
            model[sel][idx]   = d;
            written[sel][idx] = 1'b1;
         end
      end else if (exp_e) begin
         exp_d = 16'd0;
         chk_d = 1'b1;
      end else begin
         exp_d = model[sel][idx];
         chk_d = written[sel][idx];
      end

      wait_ready();
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      @(posedge clk);
      @(negedge clk);
      lat   = 0;
      found = 1'b0;
      while (!found && lat < 32) begin
         if (obs_valid) begin
            found = 1'b1;
         end else begin
            chk("wait_ready_low", 32'(obs_ready), 32'd0);
            chk("wait_busy_high", 32'(obs_busy), 32'd1);
            if (junk) begin
               req_valid = 1'b1;
               req_write = 1'($urandom);
               req_addr  = 16'($urandom);
               req_wdata = 16'($urandom);
            end else begin
               req_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
         end
      end
      chk("resp_seen", 32'(found), 32'd1);
      chk("latency", 32'(lat), 32'(wt + 1));
      chk("resp_ready_low", 32'(obs_ready), 32'd0);
      chk("resp_busy_high", 32'(obs_busy), 32'd1);
      chk("resp_err", 32'(obs_err), 32'(exp_e));
      if (chk_d) chk("resp_rdata", 32'(obs_rdata), 32'(exp_d));
      held = obs_rdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      chk("after_valid_low", 32'(obs_valid), 32'd0);
      chk("after_ready_high", 32'(obs_ready), 32'd1);
      chk("after_busy_low", 32'(obs_busy), 32'd0);
      chk("rdata_held", 32'(obs_rdata), 32'(held));
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      int n;
      repeat (2) @(negedge clk);
      chk_reset_outputs("reset_a");
      sel = 1'b1;
      #1;
      chk_reset_outputs("reset_0");
      sel = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      // Preload every word so later loads are fully predictable.
      for (int i = 0; i < DEPTH; i++) xact(1'b1, 16'(i), 16'($urandom), 1'b0);

      xact(1'b1, 16'h0010, 16'hBEEF, 1'b0);
      xact(1'b0, 16'h0010, 16'h0000, 1'b0);
      xact(1'b1, 16'h0020, 16'hC0DE, 1'b1);
      xact(1'b0, 16'h0020, 16'h0000, 1'b1);

      xact(1'b1, 16'h0000, 16'h1234, 1'b0);
      xact(1'b1, 16'h0100, 16'hAAAA, 1'b0);
      xact(1'b0, 16'h0000, 16'h0000, 1'b0);
      xact(1'b0, 16'h0100, 16'h0000, 1'b0);

      // Reset while a store waits with counter 1: store must be lost.
      xact(1'b1, 16'h0020, 16'h1111, 1'b0);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_in_wait");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 16'h0020, 16'h0000, 1'b0);

      // Reset during the response cycle: committed store survives.
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'h0030;
      req_wdata = 16'h7777;
      model[0][16'h30]   = 16'h7777;
      written[0][16'h30] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (!obs_valid && n < 20) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk("resp_before_reset", 32'(obs_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_in_resp");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xact(1'b0, 16'h0030, 16'h0000, 1'b0);

      // Randomized mix of loads and stores, including out-of-range addresses.
      for (int i = 0; i < 60; i++) begin
         logic [15:0] a;
         a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
         xact(1'($urandom), a, 16'($urandom), 1'($urandom));
      end

      // Zero-wait-state instance.
      sel = 1'b1;
      #1;
      xact(1'b1, 16'h0042, 16'h0F0F, 1'b0);
      xact(1'b0, 16'h0042, 16'h0000, 1'b0);
      for (int i = 0; i < 12; i++) begin
         logic [15:0] a;
         a = 16'($urandom_range(0, 7));
         xact(1'b1, a, 16'($urandom), 1'($urandom));
         xact(1'b0, a, 16'h0000, 1'($urandom));
      end
      sel = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
